// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: key-length encodings, round counts,
// FSM state codes and the GF(2^8) column/row transforms.
package aes_pkg;

    localparam logic [1:0] KEYLEN_128 = 2'b00;
    localparam logic [1:0] KEYLEN_192 = 2'b01;
    localparam logic [1:0] KEYLEN_256 = 2'b10;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_SBOX = 2'd2;
    localparam logic [1:0] ST_MAIN = 2'd3;

    // 2'b11 falls back to AES-128.
    function automatic logic [3:0] num_rounds(input logic [1:0] keylen);
        case (keylen)
            KEYLEN_192: return NR_192;
            KEYLEN_256: return NR_256;
            default:    return NR_128;
        endcase
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
    endfunction

    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
                gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
                gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3),
                gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3)};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mixw(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // Row r of column c takes the byte from column (c - r) mod 4.
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + 4 - r) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Four-byte AES inverse S-box: inverse affine transform followed by the
// GF(2^8) multiplicative inverse.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gm2(x);
        end
        return p;
    endfunction

    // Inverse as x^254, which also maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
        logic [7:0] a;
        a = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            a[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return gf_inv(a ^ 8'h05);
    endfunction

    assign word_o = {inv_sbox_byte(word_i[31:24]), inv_sbox_byte(word_i[23:16]),
                     inv_sbox_byte(word_i[15:8]),  inv_sbox_byte(word_i[7:0])};

endmodule

// File: rtl/aes_decipher_lanes.sv
// AES inverse-cipher round engine processing SBOX_LANES inverse S-box words per cycle.
// Defining AES_DEC_ABORT_EN adds the `abort` input.
module aes_decipher_lanes
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_LANES = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         done
`ifdef AES_DEC_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam int unsigned GROUPS = 4 / SBOX_LANES;
    // With four lanes the counter is logically absent; a constant-zero bit stands in.
    localparam int unsigned CNT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_lanes_check
        $error("aes_decipher_lanes: SBOX_LANES must be 1, 2 or 4");
    end

    logic [1:0]       state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [127:0]     block_q, block_d, sbox_block;
    logic             ready_q, ready_d, done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0][31:0] words;
    logic [1:0]       base;
    logic [31:0]      lane_in  [SBOX_LANES];
    logic [31:0]      lane_out [SBOX_LANES];

    assign words = block_q;
    assign base  = 2'(32'(cnt_q) * SBOX_LANES);

    // Word 0 is bits 127:96, i.e. packed index 3.
    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        assign lane_in[g] = words[2'd3 - (base + 2'(g))];
        aes_inv_sbox u_inv_sbox (
            .word_i (lane_in[g]),
            .word_o (lane_out[g])
        );
    end

    always_comb begin
        logic [3:0][31:0] w;
        w = block_q;
        for (int unsigned l = 0; l < SBOX_LANES; l++) begin
            w[2'd3 - (base + 2'(l))] = lane_out[l];
        end
        sbox_block = w;
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        block_d = block_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (next) begin
                    round_d = num_rounds(keylen);
                    ready_d = 1'b0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                block_d = inv_shiftrows(block ^ round_key);
                cnt_d   = '0;
                state_d = ST_SBOX;
            end
            ST_SBOX: begin
                block_d = sbox_block;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    round_d = (round_q != '0) ? round_q - 4'd1 : round_q;
                    state_d = ST_MAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (round_q != '0) begin
                    block_d = inv_shiftrows(inv_mixcolumns(block_q ^ round_key));
                    state_d = ST_SBOX;
                end else begin
                    block_d = block_q ^ round_key;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
`ifdef AES_DEC_ABORT_EN
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            round_d = '0;
            block_d = '0;
            ready_d = 1'b1;
            done_d  = 1'b0;
            cnt_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            block_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            block_q <= block_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign round     = round_q;
    assign new_block = block_q;
    assign ready     = ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_decipher_lanes.sv
// Bench for aes_decipher_lanes: one instance each for 1, 2 and 4 lanes, checked
// against FIPS-197 vectors and a byte-level inverse-cipher reference model.
module tb_aes_decipher_lanes;

    localparam logic [255:0] KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [2:0]   nxt;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic         abort;
    logic [3:0]   rnd  [3];
    logic [127:0] rkey [3];
    logic [127:0] nb   [3];
    logic [2:0]   rdy;
    logic [2:0]   dn;

    logic [127:0] rk  [16];
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rkey[g] = rk[rnd[g]];
        aes_decipher_lanes #(.SBOX_LANES(1 << g)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .next      (nxt[g]),
            .keylen    (keylen),
            .round     (rnd[g]),
            .round_key (rkey[g]),
            .block     (block),
            .new_block (nb[g]),
            .ready     (rdy[g]),
            .done      (dn[g])
`ifdef AES_DEC_ABORT_EN
            ,
            .abort     (abort)
`endif
        );
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic int unsigned nr_of(input logic [1:0] kl);
        return (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input logic [1:0] kl);
        int          nk, nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        nr = int'(nr_of(kl));
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_inv_shift(input logic [127:0] s);
        logic [127:0] o;
        int row, col;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            row = i % 4;
            col = i / 4;
            o[127 - 8*(4*((col + row) % 4) + row) -: 8] = s[127 - 8*i -: 8];
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_inv_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = isb[s[127 - 8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int unsigned nr);
        logic [127:0] s;
        s = ct ^ rk[nr];
        for (int r = int'(nr) - 1; r >= 0; r--) begin
            s = ref_inv_sub(ref_inv_shift(s)) ^ rk[r];
            if (r > 0) s = ref_inv_mix(s);
        end
        return s;
    endfunction

    // ---------------- stimulus ----------------
    task automatic run_one(input int unsigned k, input logic [1:0] kl, input logic [127:0] ct,
                           output logic [127:0] pt, output int unsigned lat, output logic pulse_ok);
        @(negedge clk);
        keylen = kl;
        block  = ct;
        nxt[k] = 1'b1;
        @(negedge clk);
        nxt[k] = 1'b0;
        keylen = 2'($urandom);
        lat    = 1;
        @(negedge clk);
        block = {$urandom, $urandom, $urandom, $urandom};
        lat   = 2;
        while (!rdy[k] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        pt       = nb[k];
        pulse_ok = dn[k];
        @(negedge clk);
        pulse_ok = pulse_ok & !dn[k] & rdy[k] & (nb[k] == pt);
    endtask

    typedef struct {
        int unsigned  lane;
        logic [1:0]   kl;
        logic [127:0] ct;
        logic [127:0] pt;
        int unsigned  lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [7:0]   inv;
        logic [127:0] pt, ct, exp_pt;
        logic [255:0] key;
        logic [1:0]   kl;
        logic         ok, seen;
        int unsigned  lat, k, exp_lat;

        reset_n = 1'b0;
        nxt     = '0;
        keylen  = '0;
        block   = '0;
        abort   = 1'b0;
        for (int r = 0; r < 16; r++) rk[r] = '0;

        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

        vecs[0] = '{0, 2'b00, CT128, PT, 52};
        vecs[1] = '{1, 2'b01, CT192, PT, 38};
        vecs[2] = '{2, 2'b01, CT192, PT, 26};
        vecs[3] = '{2, 2'b10, CT256, PT, 30};
        vecs[4] = '{2, 2'b11, CT128, PT, 22};
        vecs[5] = '{0, 2'b10, CT256, PT, 72};
        vecs[6] = '{1, 2'b00, CT128, PT, 32};

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset new_block L%0d", 1 << g), nb[g], '0);
            check($sformatf("reset ready L%0d", 1 << g), 128'(rdy[g]), 128'(1));
            check($sformatf("reset done L%0d", 1 << g), 128'(dn[g]), 128'(0));
            check($sformatf("reset round L%0d", 1 << g), 128'(rnd[g]), 128'(0));
        end
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            expand_key(KEY, vecs[i].kl);
            run_one(vecs[i].lane, vecs[i].kl, vecs[i].ct, pt, lat, ok);
            check($sformatf("vec%0d plaintext", i), pt, vecs[i].pt);
            check($sformatf("vec%0d latency", i), 128'(lat), 128'(vecs[i].lat));
            check($sformatf("vec%0d done pulse", i), 128'(ok), 128'(1));
        end

        for (int i = 0; i < 6; i++) begin
            k   = $urandom_range(0, 2);
            kl  = 2'($urandom_range(0, 3));
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ct  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key, kl);
            exp_pt  = ref_decrypt(ct, nr_of(kl));
            exp_lat = 2 + nr_of(kl) * (4 / (1 << k) + 1);
            run_one(k, kl, ct, pt, lat, ok);
            check($sformatf("rand%0d plaintext", i), pt, exp_pt);
            check($sformatf("rand%0d latency", i), 128'(lat), 128'(exp_lat));
            check($sformatf("rand%0d done pulse", i), 128'(ok), 128'(1));
        end

        // Back-to-back on the 4-lane engine, with ignored `next` pulses while busy.
        expand_key(KEY, 2'b00);
        ct = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        keylen = 2'b00; block = CT128; nxt[2] = 1'b1;
        @(negedge clk);
        nxt[2] = 1'b0; lat = 1;
        @(negedge clk);
        block = ct; lat = 2;
        while (!rdy[2] && lat < 200) begin @(negedge clk); lat++; end
        check("b2b first plaintext", nb[2], PT);
        check("b2b first latency", 128'(lat), 128'(22));
        check("b2b first done", 128'(dn[2]), 128'(1));
        nxt[2] = 1'b1;
        @(negedge clk);
        nxt[2] = 1'b0; lat = 1;
        check("b2b restart ready", 128'(rdy[2]), 128'(0));
        @(negedge clk);
        block = {$urandom, $urandom, $urandom, $urandom}; lat = 2;
        while (!rdy[2] && lat < 200) begin
            @(negedge clk);
            lat++;
            nxt[2] = (lat >= 5 && lat <= 8);
        end
        nxt[2] = 1'b0;
        check("b2b second plaintext", nb[2], ref_decrypt(ct, 10));
        check("b2b second latency", 128'(lat), 128'(22));
        check("b2b second done", 128'(dn[2]), 128'(1));
        repeat (2) @(negedge clk);
        check("busy next not queued", 128'({rdy[2], dn[2]}), 128'(2'b10));

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        keylen = 2'b00; block = CT128; nxt[0] = 1'b1;
        @(negedge clk);
        nxt[0] = 1'b0; lat = 1;
        while (lat < 19) begin @(negedge clk); lat++; end
        check("pre-reset busy", 128'(rdy[0]), 128'(0));
        reset_n = 1'b0;
        #1;
        check("mid reset new_block", nb[0], '0);
        check("mid reset ready/done", 128'({rdy[0], dn[0]}), 128'(2'b10));
        check("mid reset round", 128'(rnd[0]), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run_one(0, 2'b00, CT128, pt, lat, ok);
        check("post-reset plaintext", pt, PT);
        check("post-reset latency", 128'(lat), 128'(52));

`ifdef AES_DEC_ABORT_EN
        @(negedge clk);
        keylen = 2'b00; block = CT128; nxt[1] = 1'b1;
        @(negedge clk);
        nxt[1] = 1'b0; lat = 1;
        @(negedge clk);
        block = '0; lat = 2;
        while (rnd[1] != 4'd5 && lat < 200) begin @(negedge clk); lat++; end
        @(negedge clk);
        check("abort reached round 5", 128'(rnd[1]), 128'(5));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort new_block", nb[1], '0);
        check("abort ready/done", 128'({rdy[1], dn[1]}), 128'(2'b10));
        check("abort round", 128'(rnd[1]), 128'(0));
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen = seen | dn[1]; end
        check("abort no done", 128'(seen), 128'(0));
        run_one(1, 2'b00, CT128, pt, lat, ok);
        check("post-abort plaintext", pt, PT);
        check("post-abort latency", 128'(lat), 128'(32));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
